// File: rtl/mewb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : mewb_skid_stage
// Description : MEM/WB pipeline stage built as a two-entry (main + skid)
//               register with a valid/ready handshake. A stalled writeback
//               back-pressures data memory without dropping an in-flight
//               instruction. Includes a synchronous flush, bubble-safe
//               control output and a saturating back-pressure counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   flush      : synchronous kill of all held entries
//   stat_clr   : synchronous clear of stall_cnt
//   in_valid   : upstream entry valid
//   in_ready   : stage can accept this cycle (registered state only)
//   in_pc4 / in_alu / in_dmrd / in_rd / in_ctrl : upstream entry fields
//   out_valid  : head entry valid
//   out_ready  : writeback consumes head this cycle
//   out_pc4 / out_alu / out_dmrd / out_rd : head fields (hold when empty)
//   out_ctrl   : head control, forced to 0 when out_valid is low
//   stall_cnt  : saturating count of cycles with out_valid & !out_ready
// ============================================================================
module mewb_skid_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stat_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_dmrd,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc4,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_dmrd,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int             c_ENT_W   = 3 * DATA_W + RD_W + CTRL_W;
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic               r_rstDone;
  logic [c_ENT_W-1:0] r_main;
  logic [c_ENT_W-1:0] r_skid;
  logic [c_ENT_W-1:0] w_inEnt;
  logic [CTRL_W-1:0]  w_mainCtrl;
  logic [CNT_W-1:0]   r_stallCnt;
  logic               w_inFire;
  logic               w_outFire;
  logic               w_loadMainIn;
  logic               w_loadMainSkid;
  logic               w_loadSkid;

  assign w_inEnt = {in_pc4, in_alu, in_dmrd, in_rd, in_ctrl};

  // r_rstDone keeps in_ready low until the first edge after reset release.
  assign in_ready  = r_rstDone & (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_inFire  = in_valid & in_ready;
  assign w_outFire = out_valid & out_ready;

  // Next-state and register-load decode. Flush wins over everything; an
  // out_fire during flush is simply consumed, an in_fire is dropped.
  always_comb begin
    w_stateNext    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    if (flush) begin
      w_stateNext = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inFire) begin
            w_loadMainIn = 1'b1;
            w_stateNext  = ONE;
          end
        end
        ONE: begin
          case ({w_inFire, w_outFire})
            2'b11: w_loadMainIn = 1'b1;
            2'b10: begin
              w_loadSkid  = 1'b1;
              w_stateNext = FULL;
            end
            2'b01: w_stateNext = EMPTY;
            default: w_stateNext = ONE;
          endcase
        end
        FULL: begin
          // Skid drains into main only; it never bypasses the head.
          if (w_outFire) begin
            w_loadMainSkid = 1'b1;
            w_stateNext    = ONE;
          end
        end
        default: w_stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_rstDone <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_rstDone <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_loadMainIn) begin
        r_main <= w_inEnt;
      end else if (w_loadMainSkid) begin
        r_main <= r_skid;
      end
      if (w_loadSkid) begin
        r_skid <= w_inEnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (stat_clr) begin
      r_stallCnt <= '0;
    end else if (out_valid && !out_ready && (r_stallCnt != c_CNT_MAX)) begin
      r_stallCnt <= r_stallCnt + c_CNT_ONE;
    end
  end

  assign {out_pc4, out_alu, out_dmrd, out_rd, w_mainCtrl} = r_main;
  // A bubble must never assert ru_write downstream.
  assign out_ctrl  = w_mainCtrl & {CTRL_W{out_valid}};
  assign stall_cnt = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_mewb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mewb_skid_stage
// Description : Scoreboard bench for mewb_skid_stage. A queue-based model of
//               a two-deep FIFO predicts every head, handshake and counter
//               value; a negedge monitor compares the DUT against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mewb_skid_stage;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 3;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] dmrd;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              stat_clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pc4;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_dmrd;
  logic [RD_W-1:0]   in_rd;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc4;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_dmrd;
  logic [RD_W-1:0]   out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  mewb_skid_stage #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .stat_clr  (stat_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc4    (in_pc4),
    .in_alu    (in_alu),
    .in_dmrd   (in_dmrd),
    .in_rd     (in_rd),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc4   (out_pc4),
    .out_alu   (out_alu),
    .out_dmrd  (out_dmrd),
    .out_rd    (out_rd),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  ent_t expQ[$];
  bit   mRstDone  = 0;
  int   mCnt      = 0;
  ent_t lastHead  = '0;
  bit   holdValid = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a FIFO of capacity two, updated on each active edge or reset.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        expQ.delete();
        mRstDone  = 0;
        mCnt      = 0;
        lastHead  = '0;
        holdValid = 1;
      end else begin
        bit mv, mr, inF, outF;
        ent_t e;
        mv   = (expQ.size() > 0);
        mr   = mRstDone && (expQ.size() < 2);
        inF  = in_valid && mr;
        outF = mv && out_ready;
        if (stat_clr) mCnt = 0;
        else if (mv && !out_ready && mCnt < CNT_MAX) mCnt = mCnt + 1;
        if (flush) begin
          expQ.delete();
          holdValid = 0;
        end else begin
          if (outF) void'(expQ.pop_front());
          if (inF) begin
            e = '{pc4: in_pc4, alu: in_alu, dmrd: in_dmrd, rd: in_rd, ctrl: in_ctrl};
            expQ.push_back(e);
          end
        end
        mRstDone = 1;
      end
    end
  end

  // Monitor: compare DUT against model away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(mRstDone && (expQ.size() < 2)));
    chk("out_valid", 64'(out_valid), 64'(expQ.size() > 0));
    chk("stall_cnt", 64'(stall_cnt), 64'(mCnt));
    if (out_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_entry actual=valid required=empty at %0t", $time);
      end else begin
        chk("out_ctrl", 64'(out_ctrl), 64'(expQ[0].ctrl));
        chk("out_alu",  64'(out_alu),  64'(expQ[0].alu));
        chk("out_pc4",  64'(out_pc4),  64'(expQ[0].pc4));
        chk("out_dmrd", 64'(out_dmrd), 64'(expQ[0].dmrd));
        chk("out_rd",   64'(out_rd),   64'(expQ[0].rd));
        lastHead  = expQ[0];
        holdValid = 1;
      end
    end else begin
      chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
      if (holdValid) begin
        chk("hold_alu",  64'(out_alu),  64'(lastHead.alu));
        chk("hold_pc4",  64'(out_pc4),  64'(lastHead.pc4));
        chk("hold_dmrd", 64'(out_dmrd), 64'(lastHead.dmrd));
        chk("hold_rd",   64'(out_rd),   64'(lastHead.rd));
      end
    end
  end

  task automatic step(input logic v, input logic r, input logic f, input logic c,
                      input logic [DATA_W-1:0] alu, input logic [CTRL_W-1:0] ctrl);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    stat_clr  = c;
    in_alu    = alu;
    in_ctrl   = ctrl;
    in_pc4    = $urandom;
    in_dmrd   = $urandom;
    in_rd     = RD_W'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r, input int n);
    for (int i = 0; i < n; i++) step(1'b0, r, 1'b0, 1'b0, $urandom, CTRL_W'($urandom));
  endtask

  initial begin
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 3'b111);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h6, 3'b111);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    rst_n = 1'b1;
    idle(1'b1, 1);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Streaming, four back-to-back entries
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'(i * 16), CTRL_W'($urandom));
    idle(1'b1, 2);

    // Back-pressure fill, then release
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'hA, 3'b101);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'hB, 3'b010);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, CTRL_W'($urandom));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    idle(1'b1, 3);

    // Bubble safety
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hC0DE, 3'b111);
    idle(1'b1, 3);

    // Flush while FULL with a simultaneous in_valid
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 3'b111);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h2, 3'b111);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h3, 3'b111);
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    idle(1'b1, 5);

    // Counter saturation and clear
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 3'b001);
    idle(1'b0, 20);
    chk("cnt_sat", 64'(stall_cnt), 64'(CNT_MAX));
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 3'b000);
    chk("cnt_clr", 64'(stall_cnt), 64'(0));
    idle(1'b0, 3);
    chk("cnt_resume", 64'(stall_cnt), 64'(3));
    idle(1'b1, 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 30) == 0), 1'($urandom_range(0, 40) == 0),
           $urandom, CTRL_W'($urandom));
    end
    idle(1'b1, 3);

    // Asynchronous reset while FULL
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'hD1, 3'b101);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'hD2, 3'b110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(0));
    chk("arst_out_alu", 64'(out_alu), 64'(0));
    chk("arst_out_ctrl", 64'(out_ctrl), 64'(0));
    chk("arst_stall_cnt", 64'(stall_cnt), 64'(0));
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hEE, 3'b111);
    rst_n = 1'b1;
    idle(1'b1, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hF00D, 3'b100);
    chk("arst_first_alu", 64'(out_alu), 64'(32'hF00D));
    idle(1'b1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
